// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
// Used by fifo_wr_arbiter, its interface and rr_picker.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_st_e;

  // Index width that stays at least one bit for n == 1
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester + FIFO write-side bundle for fifo_wr_arbiter.
// slave: arbiter side, master: requesters/FIFO side.
import fifo_arb_pkg::*;

interface fifo_wr_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int BUF_WIDTH = 3
);
  logic [N_REQ-1:0]          req;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          ack;
  logic                      fifo_full;
  logic [BUF_WIDTH:0]        fifo_count;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wdata;
  logic [idx_w(N_REQ)-1:0]   owner_id;
  logic                      busy;

  modport slave (
    input  req, req_data,
    input  fifo_full, fifo_count,
    output gnt, ack,
    output fifo_wr_en, fifo_wdata,
    output owner_id, busy
  );

  modport master (
    output req, req_data,
    output fifo_full, fifo_count,
    input  gnt, ack,
    input  fifo_wr_en, fifo_wdata,
    input  owner_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating priority encoder: first set req after i_last,
// wrapping around; i_last itself has lowest priority.
import fifo_arb_pkg::*;

module rr_picker #(
  parameter int N_REQ = 4,
  parameter int OW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [OW-1:0]    i_last,
  output logic [OW-1:0]    o_winner,
  output logic             o_valid
);

  // Scan farthest-first so the nearest candidate wins
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      int j;
      j = int'(i_last) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (i_req[j]) begin
        o_winner = OW'(j);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter sharing one FIFO among N_REQ producers.
// Define FIFO_WR_ARB_WMARK_EN to also block new grants at fifo_count >= HIGH_WMARK.
import fifo_arb_pkg::*;

module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int BUF_WIDTH  = 3,
  parameter int MAX_BURST  = 4,
  parameter int HIGH_WMARK = 6
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int OW = idx_w(N_REQ);
  localparam int BW = idx_w(MAX_BURST);

  arb_st_e          r_state;
  arb_st_e          w_state_n;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_n;
  logic [OW-1:0]    r_own;
  logic [OW-1:0]    w_own_n;
  logic [OW-1:0]    r_last;
  logic [OW-1:0]    w_last_n;
  logic [BW-1:0]    r_beat;
  logic [BW-1:0]    w_beat_n;

  logic [OW-1:0]    w_pick;
  logic             w_pick_vld;
  logic             w_permit;
  logic             w_acc;
  logic             w_last_beat;

  rr_picker #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_winner (w_pick),
    .o_valid  (w_pick_vld)
  );

`ifdef FIFO_WR_ARB_WMARK_EN
  assign w_permit = !bus.fifo_full &&
                    (int'(bus.fifo_count) < HIGH_WMARK);
`else
  logic w_unused;
  assign w_unused = ^{bus.fifo_count, (HIGH_WMARK > 0)};
  assign w_permit = !bus.fifo_full;
`endif

  assign bus.ack = r_gnt & bus.req &
                   {N_REQ{!bus.fifo_full}};
  assign w_acc       = |bus.ack;
  assign w_last_beat = (r_beat == BW'(MAX_BURST - 1));

  assign bus.gnt        = r_gnt;
  assign bus.owner_id   = r_own;
  assign bus.busy       = (r_state == ST_BURST);
  assign bus.fifo_wr_en = w_acc;
  assign bus.fifo_wdata = (r_state == ST_BURST) ?
    bus.req_data[r_own*DATA_W +: DATA_W] : '0;

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_own_n   = r_own;
    w_last_n  = r_last;
    w_beat_n  = r_beat;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_vld && w_permit) begin
          w_gnt_n         = '0;
          w_gnt_n[w_pick] = 1'b1;
          w_own_n         = w_pick;
          w_beat_n        = '0;
          w_state_n       = ST_BURST;
        end
      end
      ST_BURST: begin
        // Owner dropping req ends the burst even mid-stall
        if (!bus.req[r_own] || (w_acc && w_last_beat)) begin
          w_gnt_n   = '0;
          w_last_n  = r_own;
          w_beat_n  = '0;
          w_state_n = ST_IDLE;
        end else if (w_acc) begin
          w_beat_n = r_beat + 1'b1;
        end
      end
      default: begin
        w_gnt_n   = '0;
        w_state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_own   <= '0;
      r_last  <= OW'(N_REQ - 1);
      r_beat  <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_own   <= w_own_n;
      r_last  <= w_last_n;
      r_beat  <= w_beat_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4).
// Expected writes are queued per scenario; a negedge monitor pops them.
import fifo_arb_pkg::*;

module tb_fifo_wr_arbiter;

  typedef struct {
    int         own;
    logic [7:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if bus ();

  fifo_wr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wr_t q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  exp_seq[4];
  int  seq[4];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int own, input int n);
    for (int b = 0; b < n; b++) begin
      wr_t e;
      e.own  = own;
      e.data = 8'(own * 64 + exp_seq[own] % 64);
      q.push_back(e);
      exp_seq[own]++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag,
                         input int k,
                         input logic [3:0] eg);
    chk($sformatf("%s_gnt_k%0d", tag, k),
        32'(bus.gnt), 32'(eg));
    chk($sformatf("%s_busy_k%0d", tag, k),
        32'(bus.busy), 32'(eg != 4'b0));
  endtask

  // Requester data model and write monitor
  initial begin
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      bus.req_data[i*8 +: 8] = 8'(i * 64);
    end
    forever begin
      @(negedge clk);
      if (bus.fifo_wr_en) begin
        if (q.size() == 0) begin
          chk("wr_unexp", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_own", 32'(bus.owner_id), 32'(e.own));
          chk("wr_data", 32'(bus.fifo_wdata), 32'(e.data));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.ack[i]) begin
          seq[i]++;
          bus.req_data[i*8 +: 8] = 8'(i * 64 + seq[i] % 64);
        end
      end
    end
  end

  initial begin
    int d;
    logic [3:0] eg;
    for (int i = 0; i < 4; i++) exp_seq[i] = 0;
    bus.req        = '0;
    bus.fifo_full  = 1'b0;
    bus.fifo_count = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_own", 32'(bus.owner_id), 32'd0);
    chk("rst_wr", 32'(bus.fifo_wr_en), 32'd0);
    cyc();
    rst_n = 1'b1;

    // All four requesting: rotation 0,1,2,3,0
    for (int b = 0; b < 5; b++) push_exp(b % 4, 4);
    bus.req = 4'hF;
    for (int k = 1; k <= 25; k++) begin
      cyc();
      if (k == 25) bus.req = '0;
      @(negedge clk);
      eg = (k % 5 == 0) ? 4'b0 : 4'(1 << (((k - 1) / 5) % 4));
      chk_gnt("s2", k, eg);
      if (eg != 4'b0)
        chk($sformatf("s2_own_k%0d", k),
            32'(bus.owner_id), 32'(((k - 1) / 5) % 4));
    end

    // Single requester 2: 4 beats, idle, re-grant
    push_exp(2, 6);
    cyc();
    bus.req = 4'b0100;
    @(negedge clk);
    chk("s1_lat_gnt", 32'(bus.gnt), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 8) bus.req = '0;
      @(negedge clk);
      eg = (k == 5 || k == 9) ? 4'b0 : 4'b0100;
      chk_gnt("s1", k, eg);
      if (k == 8) chk("s1_drop_wr", 32'(bus.fifo_wr_en), 32'd0);
    end

    // FIFO full for 3 cycles after beat 2
    push_exp(1, 4);
    cyc();
    bus.req = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 3) bus.fifo_full = 1'b1;
      if (k == 6) bus.fifo_full = 1'b0;
      if (k == 8) bus.req = '0;
      @(negedge clk);
      eg = (k <= 7) ? 4'b0010 : 4'b0;
      chk_gnt("s3", k, eg);
      chk($sformatf("s3_wr_k%0d", k), 32'(bus.fifo_wr_en),
          32'(k <= 2 || k == 6 || k == 7));
    end

    // Owner 3 drops after one beat; 0 granted next
    push_exp(3, 1);
    push_exp(0, 4);
    cyc();
    bus.req = 4'b1001;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 2) bus.req = 4'b0001;
      if (k == 8) bus.req = '0;
      @(negedge clk);
      eg = (k <= 2) ? 4'b1000 :
           (k >= 4 && k <= 7) ? 4'b0001 : 4'b0;
      chk_gnt("s4", k, eg);
      if (k == 2) chk("s4_drop_wr", 32'(bus.fifo_wr_en), 32'd0);
    end

    // Asynchronous reset mid-burst
    push_exp(0, 1);
    cyc();
    bus.req = 4'b0001;
    cyc();
    @(negedge clk);
    chk_gnt("s5a", 1, 4'b0001);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("s5_rst_busy", 32'(bus.busy), 32'd0);
    chk("s5_rst_wr", 32'(bus.fifo_wr_en), 32'd0);
    bus.req = 4'b1001;
    cyc();
    cyc();
    rst_n = 1'b1;
    push_exp(0, 4);
    push_exp(3, 4);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 5) bus.req = 4'b1000;
      if (k == 10) bus.req = '0;
      @(negedge clk);
      eg = (k <= 4) ? 4'b0001 :
           (k >= 6 && k <= 9) ? 4'b1000 : 4'b0;
      chk_gnt("s5", k, eg);
    end

    // High watermark gating of new grants
`ifdef FIFO_WR_ARB_WMARK_EN
    d = 2;
`else
    d = 0;
`endif
    push_exp(2, 4);
    cyc();
    bus.fifo_count = 4'd6;
    bus.req        = 4'b0100;
    for (int k = 1; k <= d + 5; k++) begin
      cyc();
      if (d > 0 && k == d) bus.fifo_count = 4'd5;
      if (k == d + 5) bus.req = '0;
      @(negedge clk);
      eg = (k > d && k <= d + 4) ? 4'b0100 : 4'b0;
      chk_gnt("s6", k, eg);
    end
    bus.fifo_count = '0;

    // Idle arbiter does not grant into a full FIFO
    push_exp(1, 4);
    cyc();
    bus.fifo_full = 1'b1;
    bus.req       = 4'b0010;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      if (k == 2) bus.fifo_full = 1'b0;
      if (k == 7) bus.req = '0;
      @(negedge clk);
      eg = (k >= 3 && k <= 6) ? 4'b0010 : 4'b0;
      chk_gnt("s7", k, eg);
    end

    repeat (3) cyc();
    @(negedge clk);
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
